// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage in-order core: carries decoded controls D->E->M->W,
// detects load-use hazards, resolves branches in M and selects E-stage operand forwarding.
module pipe_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       regwriteD,
  input  logic       regdstD,
  input  logic       alusrcD,
  input  logic       branchD,
  input  logic       memwriteD,
  input  logic       memtoregD,
  input  logic       jumpD,
  input  logic [1:0] aluopD,
  input  logic       validD,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] writeregE,
  input  logic       zeroM,
  output logic       regwriteE,
  output logic       regdstE,
  output logic       alusrcE,
  output logic       branchE,
  output logic       memwriteE,
  output logic       memtoregE,
  output logic [1:0] aluopE,
  output logic       regwriteM,
  output logic       memwriteM,
  output logic       memtoregM,
  output logic       branchM,
  output logic       regwriteW,
  output logic       memtoregW,
  output logic [4:0] writeregM,
  output logic [4:0] writeregW,
  output logic       pcsrcM,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  logic [7:0] r_ctlE;   // {regwrite, regdst, alusrc, branch, memwrite, memtoreg, aluop}
  logic [4:0] r_rsE, r_rtE;
  logic [3:0] r_ctlM;   // {regwrite, memwrite, memtoreg, branch}
  logic [4:0] r_wregM;
  logic [1:0] r_ctlW;   // {regwrite, memtoreg}
  logic [4:0] r_wregW;

  logic w_pcsrc, w_lwstall, w_stall, w_bubE, w_bubM;

  assign {regwriteE, regdstE, alusrcE, branchE, memwriteE, memtoregE, aluopE} = r_ctlE;
  assign {regwriteM, memwriteM, memtoregM, branchM} = r_ctlM;
  assign {regwriteW, memtoregW} = r_ctlW;
  assign writeregM = r_wregM;
  assign writeregW = r_wregW;

  assign w_pcsrc   = r_ctlM[0] & zeroM;
  assign w_lwstall = r_ctlE[2] && (r_rtE != 5'd0) && ((r_rtE == rsD) || (r_rtE == rtD));
  // A taken branch discards the stalled instruction anyway, so the flush overrides the stall.
  assign w_stall   = w_lwstall & ~w_pcsrc;
  assign w_bubE    = reset | ~validD | w_stall | w_pcsrc;
  assign w_bubM    = reset | w_pcsrc;

  assign pcsrcM = w_pcsrc;
  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushD = w_pcsrc | (jumpD & validD & ~w_stall);

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wm,
                                          input logic rwm, input logic [4:0] ww, input logic rww);
    if (src != 5'd0 && src == wm && rwm)      fwd_sel = 2'b10;
    else if (src != 5'd0 && src == ww && rww) fwd_sel = 2'b01;
    else                                      fwd_sel = 2'b00;
  endfunction

  assign forwardAE = fwd_sel(r_rsE, r_wregM, r_ctlM[3], r_wregW, r_ctlW[1]);
  assign forwardBE = fwd_sel(r_rtE, r_wregM, r_ctlM[3], r_wregW, r_ctlW[1]);

  always_ff @(posedge clk) begin
    if (w_bubE) begin
      r_ctlE <= 8'd0;
      r_rsE  <= 5'd0;
      r_rtE  <= 5'd0;
    end else begin
      r_ctlE <= {regwriteD, regdstD, alusrcD, branchD, memwriteD, memtoregD, aluopD};
      r_rsE  <= rsD;
      r_rtE  <= rtD;
    end

    if (w_bubM) begin
      r_ctlM  <= 4'd0;
      r_wregM <= 5'd0;
    end else begin
      r_ctlM  <= {r_ctlE[7], r_ctlE[3], r_ctlE[2], r_ctlE[4]};
      r_wregM <= writeregE;
    end

    if (reset) begin
      r_ctlW  <= 2'd0;
      r_wregW <= 5'd0;
    end else begin
      r_ctlW  <= {r_ctlM[3], r_ctlM[1]};
      r_wregW <= r_wregM;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table with hand-computed
// combinational (pre-edge) and stage-register (post-edge) expectations.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic regwriteD, regdstD, alusrcD, branchD, memwriteD, memtoregD, jumpD;
  logic [1:0] aluopD;
  logic validD;
  logic [4:0] rsD, rtD, writeregE;
  logic zeroM;
  logic regwriteE, regdstE, alusrcE, branchE, memwriteE, memtoregE;
  logic [1:0] aluopE;
  logic regwriteM, memwriteM, memtoregM, branchM, regwriteW, memtoregW;
  logic [4:0] writeregM, writeregW;
  logic pcsrcM, stallF, stallD, flushD;
  logic [1:0] forwardAE, forwardBE;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .regwriteD(regwriteD), .regdstD(regdstD), .alusrcD(alusrcD), .branchD(branchD),
    .memwriteD(memwriteD), .memtoregD(memtoregD), .jumpD(jumpD), .aluopD(aluopD),
    .validD(validD), .rsD(rsD), .rtD(rtD), .writeregE(writeregE), .zeroM(zeroM),
    .regwriteE(regwriteE), .regdstE(regdstE), .alusrcE(alusrcE), .branchE(branchE),
    .memwriteE(memwriteE), .memtoregE(memtoregE), .aluopE(aluopE),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .memtoregM(memtoregM), .branchM(branchM),
    .regwriteW(regwriteW), .memtoregW(memtoregW), .writeregM(writeregM), .writeregW(writeregW),
    .pcsrcM(pcsrcM), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .forwardAE(forwardAE), .forwardBE(forwardBE)
  );

  always #5 clk = ~clk;

  // D control words {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump}
  localparam logic [6:0] NO = 7'b0000000, RT = 7'b1100000, LW = 7'b1010010,
                         SW = 7'b0010100, BQ = 7'b0001000, JP = 7'b0000001;
  // E views {regwrite, regdst, alusrc, branch, memwrite, memtoreg, aluop}
  localparam logic [7:0] ER = 8'hC2, ELW = 8'hA4, ESW = 8'h28, EBQ = 8'h11;
  // comb views {pcsrc, stallF, stallD, flushD, fwdA, fwdB}
  localparam logic [7:0] C0 = 8'h00, CFL = 8'b1001_0000, CST = 8'b0110_0000, CJ = 8'b0001_0000;

  typedef struct {
    logic       rst, vld;
    logic [6:0] ctl;
    logic [1:0] aop;
    logic [4:0] rs, rt, wre;
    logic       z, chkc;
    logic [7:0] c, e;
    logic [3:0] m;
    logic [1:0] w;
    logic [4:0] wm, ww;
  } vec_t;

  vec_t tbl[$];
  int nrun = 0, nfail = 0;

  function automatic vec_t v(logic rst, logic vld, logic [6:0] ctl, logic [1:0] aop,
                             logic [4:0] rs, logic [4:0] rt, logic [4:0] wre, logic z,
                             logic chkc, logic [7:0] c, logic [7:0] e, logic [3:0] m,
                             logic [1:0] w, logic [4:0] wm, logic [4:0] ww);
    vec_t t;
    t.rst = rst; t.vld = vld; t.ctl = ctl; t.aop = aop; t.rs = rs; t.rt = rt; t.wre = wre;
    t.z = z; t.chkc = chkc; t.c = c; t.e = e; t.m = m; t.w = w; t.wm = wm; t.ww = ww;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; validD = t.vld;
    {regwriteD, regdstD, alusrcD, branchD, memwriteD, memtoregD, jumpD} = t.ctl;
    aluopD = t.aop; rsD = t.rs; rtD = t.rt; writeregE = t.wre; zeroM = t.z;
  endtask

  function automatic logic [7:0] comb_v();
    return {pcsrcM, stallF, stallD, flushD, forwardAE, forwardBE};
  endfunction

  function automatic logic [23:0] regs_v();
    return {regwriteE, regdstE, alusrcE, branchE, memwriteE, memtoregE, aluopE,
            regwriteM, memwriteM, memtoregM, branchM, regwriteW, memtoregW, writeregM, writeregW};
  endfunction

  initial begin
    //               rst vld ctl aop   rs  rt  wrE z  chk comb          E    M        W      wrM wrW
    // reset, then R-type flowing E->M->W
    tbl.push_back(v(1, 1, RT, 2'b10, 1,  2,  0, 0, 0, C0,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(1, 1, RT, 2'b10, 1,  2,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 1,  2,  0, 0, 1, C0,           ER,  4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  3, 0, 1, C0,           0,   4'b1000, 2'b00, 3,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b10, 0,  3));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    // forwarding: M priority, W-only, and register 0
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  0,  0, 0, 1, C0,           ER,  4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  0,  9, 0, 1, C0,           ER,  4'b1000, 2'b00, 9,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 9,  4,  9, 0, 1, C0,           ER,  4'b1000, 2'b10, 9,  9));
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  9,  4, 0, 1, 8'b0000_1000, ER,  4'b1000, 2'b10, 4,  9));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, 8'b0000_0001, 0,   4'b1000, 2'b10, 0,  4));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b10, 0,  0));
    // SW then LW with load-use stall on rsD
    tbl.push_back(v(0, 1, SW, 2'b00, 0,  0,  0, 0, 1, C0,           ESW, 4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, LW, 2'b00, 1,  8,  0, 0, 1, C0,           ELW, 4'b0100, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 8,  3,  8, 0, 1, CST,          0,   4'b1010, 2'b00, 8,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 8,  3,  0, 0, 1, C0,           ER,  4'b0000, 2'b11, 0,  8));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, 8'b0000_0100, 0,   4'b1000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b10, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    // taken branch: E and M squashed, W still advances
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  0,  0, 0, 1, C0,           ER,  4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, BQ, 2'b01, 1,  2,  5, 0, 1, C0,           EBQ, 4'b1000, 2'b00, 5,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 3,  4, 12, 0, 1, C0,           ER,  4'b0001, 2'b10, 12, 5));
    tbl.push_back(v(0, 1, RT, 2'b10, 6,  7,  9, 1, 1, CFL,          0,   4'b0000, 2'b00, 0,  12));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 1, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    // load-use stall coincident with taken branch
    tbl.push_back(v(0, 1, BQ, 2'b01, 1,  2,  0, 0, 1, C0,           EBQ, 4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, LW, 2'b00, 1,  8,  0, 0, 1, C0,           ELW, 4'b0001, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 8,  3,  8, 1, 1, CFL,          0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    // jump flush, gated by validD and by stall
    tbl.push_back(v(0, 1, JP, 2'b00, 0,  0,  0, 0, 1, CJ,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, JP, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, LW, 2'b00, 0,  8,  0, 0, 1, C0,           ELW, 4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, JP, 2'b00, 8,  0,  8, 0, 1, CST,          0,   4'b1010, 2'b00, 8,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b11, 0,  8));
    // LW to r0 never stalls
    tbl.push_back(v(0, 1, LW, 2'b00, 0,  0,  0, 0, 1, C0,           ELW, 4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  0,  0, 0, 1, C0,           ER,  4'b1010, 2'b00, 0,  0));
    // reset pulse with a full pipeline
    tbl.push_back(v(0, 1, RT, 2'b10, 0,  0,  6, 0, 1, C0,           ER,  4'b1000, 2'b11, 6,  0));
    tbl.push_back(v(1, 1, RT, 2'b10, 0,  0,  6, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));
    tbl.push_back(v(0, 0, NO, 2'b00, 0,  0,  0, 0, 1, C0,           0,   4'b0000, 2'b00, 0,  0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].chkc) chk("comb", i, {24'd0, comb_v()}, {24'd0, tbl[i].c});
      @(posedge clk); #1;
      chk("regs", i, {8'd0, regs_v()},
          {8'd0, tbl[i].e, tbl[i].m, tbl[i].w, tbl[i].wm, tbl[i].ww});
    end

    // pcsrcM follows zeroM combinationally while a branch sits in M
    drive(v(0, 1, BQ, 2'b01, 1, 2, 0, 0, 0, C0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(v(0, 0, NO, 2'b00, 0, 0, 0, 0, 0, C0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("pcsrc_z0", 100, {31'd0, pcsrcM}, 32'd0);
    chk("flush_z0", 100, {31'd0, flushD}, 32'd0);
    zeroM = 1'b1; #1;
    chk("pcsrc_z1", 101, {31'd0, pcsrcM}, 32'd1);
    chk("flush_z1", 101, {31'd0, flushD}, 32'd1);
    zeroM = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, %0d checks done", nrun);
    $fatal(1);
  end
endmodule
